// File: rtl/sp1_stkctl_pkg.sv
// Shared types for the stack controller: op and FSM state encodings.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sp1_stkctl_pkg;

  localparam int SP1_DW = 32;
  localparam int SP1_AW = 6;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACC   = 2'b01,
    ST_RWAIT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/sp1_stkctl_if.sv
// Request/ack handshake between the evaluator core and the stack controller.
// Latency: none (wiring only).
// Backpressure: requests are only honoured while busy is low; others are dropped.
interface sp1_stkctl_if
  import sp1_stkctl_pkg::*;
#(
  parameter int DW = SP1_DW
) ();

  logic          req;
  op_e           op;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;
  logic          busy;

  // core side issues requests
  modport master (
    output req, op, wdata,
    input  ack, err, rdata, busy
  );

  // stack controller side answers them
  modport slave (
    input  req, op, wdata,
    output ack, err, rdata, busy
  );

endinterface

// File: rtl/sp1_stkctl.sv
// Stack controller driving a 2**AW x DW single-port RAM; owns sp, returns pop/peek data.
// Latency: push ack 2 edges after req, pop/peek 3, clear/error 1 (all outputs registered).
// Backpressure: req ignored (not queued) while busy; next req accepted on the edge ending ack.
// Optional: define SP1_STKCTL_HWM_EN to build the high-water-mark register on hwm.
module sp1_stkctl
  import sp1_stkctl_pkg::*;
#(
  parameter int DW = SP1_DW,
  parameter int AW = SP1_AW
) (
  input  logic          clk,
  input  logic          rst,
  sp1_stkctl_if.slave   bus,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   hwm,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] SP_ONE = (AW+1)'(1);
  localparam logic [AW:0] SP_MAX = SP_ONE << AW;

  state_e        state;
  op_e           op_q;
  logic [AW:0]   sp;
  logic          ack_q;
  logic          err_q;
  logic          busy_q;
  logic [DW-1:0] rdata_q;
  logic [AW:0]   sp_inc;
  logic [AW:0]   sp_dec;

`ifdef SP1_STKCTL_HWM_EN
  logic [AW:0]   hwm_q;
  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;

  // neighbour values of sp used for addressing and for the commit edges
  always_comb begin
    sp_inc = sp + SP_ONE;
    sp_dec = sp - SP_ONE;
  end

  // request FSM: RAM strobes, stack pointer, status flags and ack are all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_PUSH;
      sp      <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ram_cs  <= 1'b0;
      ram_we  <= 1'b0;
      ram_adr <= '0;
      ram_din <= '0;
`ifdef SP1_STKCTL_HWM_EN
      hwm_q   <= '0;
`endif
    end else begin
      // strobes and pulses are single-cycle unless re-armed below
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        // DONE also accepts a request so ops can run back to back
        ST_IDLE, ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          if (bus.req) begin
            op_q <= bus.op;
            case (bus.op)
              OP_PUSH: begin
                if (full) begin
                  state <= ST_DONE;
                  ack_q <= 1'b1;
                  err_q <= 1'b1;
                end else begin
                  state   <= ST_ACC;
                  busy_q  <= 1'b1;
                  ram_cs  <= 1'b1;
                  ram_we  <= 1'b1;
                  ram_adr <= sp[AW-1:0];
                  ram_din <= bus.wdata;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  state <= ST_DONE;
                  ack_q <= 1'b1;
                  err_q <= 1'b1;
                end else begin
                  state   <= ST_ACC;
                  busy_q  <= 1'b1;
                  ram_cs  <= 1'b1;
                  ram_adr <= sp_dec[AW-1:0];
                end
              end
              default: begin
                // clear never touches the RAM
                state <= ST_DONE;
                ack_q <= 1'b1;
                sp    <= '0;
                full  <= 1'b0;
                empty <= 1'b1;
`ifdef SP1_STKCTL_HWM_EN
                hwm_q <= '0;
`endif
              end
            endcase
          end
        end
        ST_ACC: begin
          if (op_q == OP_PUSH) begin
            // write lands on this edge, so the push commits here
            state  <= ST_DONE;
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
            sp     <= sp_inc;
            full   <= (sp_inc == SP_MAX);
            empty  <= 1'b0;
`ifdef SP1_STKCTL_HWM_EN
            if (sp_inc > hwm_q) hwm_q <= sp_inc;
`endif
          end else begin
            state <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          // RAM dout is stable now; capture it and retire the pop
          state   <= ST_DONE;
          ack_q   <= 1'b1;
          busy_q  <= 1'b0;
          rdata_q <= ram_dout;
          if (op_q == OP_POP) begin
            sp    <= sp_dec;
            full  <= 1'b0;
            empty <= (sp_dec == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
